// File: rtl/fuser_seq_nmod_pkg.sv
// Shared items for the sequential N-modality fuser: state encodings,
// tie-mode constants and the ceil-log2 helper used for counter widths.
package fuser_seq_nmod_pkg;

    typedef enum logic [1:0] {
        FUSER_IDLE    = 2'd0,
        FUSER_COMPUTE = 2'd1,
        FUSER_DONE    = 2'd2
    } fuser_state_e;

    // Tie resolution for even modality counts.
    localparam int TIE_ZERO   = 0;
    localparam int TIE_ROTATE = 1;

    // Smallest w such that 2**w >= n.
    function automatic int ceil_log2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fuser_seq_nmod_majority_chunk.sv
// Combinational bitwise majority over one CHUNK_WIDTH slice of every
// modality. Ties (possible only for an even NUM_MOD) resolve to 0 or to the
// supplied tie bit, depending on TIE_MODE.
module fuser_seq_nmod_majority_chunk
    import fuser_seq_nmod_pkg::*;
#(
    parameter int NUM_MOD     = 3,
    parameter int CHUNK_WIDTH = 200,
    parameter int TIE_MODE    = TIE_ROTATE
) (
    input  logic [NUM_MOD*CHUNK_WIDTH-1:0] chunk_in,
    input  logic [CHUNK_WIDTH-1:0]         tie_bits,
    output logic [CHUNK_WIDTH-1:0]         maj_out
);

    localparam int             CW   = ceil_log2(NUM_MOD + 1);
    localparam logic [CW-1:0]  HALF = CW'(NUM_MOD / 2);
    localparam bit             EVEN = ((NUM_MOD % 2) == 0);

    logic [CW-1:0] cnt [CHUNK_WIDTH];

    // Per-bit popcount across modalities; modality m sits at [m*CHUNK_WIDTH +: CHUNK_WIDTH].
    always_comb begin
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            cnt[i] = '0;
            for (int m = 0; m < NUM_MOD; m++) begin
                cnt[i] = cnt[i] + CW'(chunk_in[m*CHUNK_WIDTH + i]);
            end
        end
    end

    // Threshold each count; an exact half count is a tie and uses the tie rule.
    always_comb begin
        maj_out = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (cnt[i] > HALF) begin
                maj_out[i] = 1'b1;
            end else if (EVEN && (cnt[i] == HALF)) begin
                maj_out[i] = (TIE_MODE == TIE_ROTATE) ? tie_bits[i] : 1'b0;
            end else begin
                maj_out[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fuser_seq_nmod.sv
// Sequential N-modality bundler. Captures all modalities in one all-or-nothing
// handshake, resolves CHUNK_WIDTH dimensions per cycle through one shared
// majority datapath, then holds the registered result until downstream
// accepts it. A new vector may be accepted on the same edge the old one is
// taken, so streaming throughput is one vector per NUM_CHUNKS+1 cycles.
//
// Handshake: a transfer on either side happens on a rising edge where valid
// and ready are both high. hvin_ready depends only on state and hvout_ready,
// never on hvin_valid; hvout_valid stays high and hvout stays stable until the
// transfer edge.
module fuser_seq_nmod
    import fuser_seq_nmod_pkg::*;
#(
    parameter int HV_DIMENSION = 2000,
    parameter int NUM_MOD      = 3,
    parameter int CHUNK_WIDTH  = 200,
    parameter int TIE_MODE     = TIE_ROTATE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_MOD-1:0]              hvin_valid,
    input  logic [NUM_MOD*HV_DIMENSION-1:0] hvin,
    output logic                            hvin_ready,
    output logic                            hvout_valid,
    input  logic                            hvout_ready,
    output logic [HV_DIMENSION-1:0]         hvout,
    output logic [1:0]                      state_dbg
);

    localparam int NUM_CHUNKS = HV_DIMENSION / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? ceil_log2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if ((HV_DIMENSION % CHUNK_WIDTH) != 0) begin : g_bad_chunk
        $error("fuser_seq_nmod: HV_DIMENSION must be a multiple of CHUNK_WIDTH");
    end
    if (NUM_MOD < 2) begin : g_bad_mod
        $error("fuser_seq_nmod: NUM_MOD must be at least 2");
    end

    fuser_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap_en;
    logic             chunk_wr;
    logic             accept;

    logic [NUM_MOD*HV_DIMENSION-1:0] cap_q;
    logic [HV_DIMENSION-1:0]         tie_vec;
    logic [NUM_MOD*CHUNK_WIDTH-1:0]  chunk_in;
    logic [CHUNK_WIDTH-1:0]          tie_chunk;
    logic [CHUNK_WIDTH-1:0]          maj_chunk;

    // Ready is forced low while reset is asserted, even though state reads IDLE.
    assign hvin_ready  = rst_n && ((state_q == FUSER_IDLE) ||
                                   ((state_q == FUSER_DONE) && hvout_ready));
    assign accept      = hvin_ready && (&hvin_valid);
    assign hvout_valid = (state_q == FUSER_DONE);
    assign state_dbg   = state_q;

    // Tie bit for dimension i is modality-0 bit (i+1), wrapping at the top.
    assign tie_vec = {cap_q[0], cap_q[HV_DIMENSION-1:1]};

    // Next-state logic: capture on accept, walk the chunks, hold in DONE until taken.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_en   = 1'b0;
        chunk_wr = 1'b0;
        case (state_q)
            FUSER_IDLE: begin
                if (accept) begin
                    state_d = FUSER_COMPUTE;
                    cap_en  = 1'b1;
                end
            end
            FUSER_COMPUTE: begin
                chunk_wr = 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    state_d = FUSER_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FUSER_DONE: begin
                if (hvout_ready) begin
                    if (accept) begin
                        state_d = FUSER_COMPUTE;
                        cap_en  = 1'b1;
                    end else begin
                        state_d = FUSER_IDLE;
                    end
                end
            end
            default: begin
                state_d = FUSER_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and chunk counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FUSER_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the current chunk of every captured modality and of the tie vector.
    always_comb begin
        chunk_in  = '0;
        for (int m = 0; m < NUM_MOD; m++) begin
            chunk_in[m*CHUNK_WIDTH +: CHUNK_WIDTH] =
                cap_q[m*HV_DIMENSION + int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
        end
        tie_chunk = tie_vec[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    fuser_seq_nmod_majority_chunk #(
        .NUM_MOD     (NUM_MOD),
        .CHUNK_WIDTH (CHUNK_WIDTH),
        .TIE_MODE    (TIE_MODE)
    ) u_majority (
        .chunk_in (chunk_in),
        .tie_bits (tie_chunk),
        .maj_out  (maj_chunk)
    );

    // Capture registers load only on accept; hvout is written one chunk per COMPUTE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            hvout <= '0;
        end else begin
            if (cap_en) begin
                cap_q <= hvin;
            end
            if (chunk_wr) begin
                hvout[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH] <= maj_chunk;
            end
        end
    end

endmodule

// File: tb/tb_fuser_seq_nmod.sv
// Directed bench for fuser_seq_nmod: one 3-modality instance for handshake,
// timing, reset and streaming, plus two 4-modality instances for the tie rules.
module tb_fuser_seq_nmod;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic clk = 1'b0;
    logic rst_n;

    // 3-modality instance
    logic [2:0]  a_valid;
    logic [23:0] a_hvin;
    logic        a_in_rdy, a_out_vld, a_out_rdy;
    logic [7:0]  a_hvout;
    logic [1:0]  a_state;

    // 4-modality instances share their inputs
    logic [3:0]  t_valid;
    logic [31:0] t_hvin;
    logic        t_out_rdy;
    logic        b_in_rdy, b_out_vld, c_in_rdy, c_out_vld;
    logic [7:0]  b_hvout, c_hvout;
    logic [1:0]  b_state, c_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fuser_seq_nmod #(.HV_DIMENSION(8), .NUM_MOD(3), .CHUNK_WIDTH(2), .TIE_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .hvin_valid(a_valid), .hvin(a_hvin),
        .hvin_ready(a_in_rdy), .hvout_valid(a_out_vld), .hvout_ready(a_out_rdy),
        .hvout(a_hvout), .state_dbg(a_state)
    );

    fuser_seq_nmod #(.HV_DIMENSION(8), .NUM_MOD(4), .CHUNK_WIDTH(2), .TIE_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .hvin_valid(t_valid), .hvin(t_hvin),
        .hvin_ready(b_in_rdy), .hvout_valid(b_out_vld), .hvout_ready(t_out_rdy),
        .hvout(b_hvout), .state_dbg(b_state)
    );

    fuser_seq_nmod #(.HV_DIMENSION(8), .NUM_MOD(4), .CHUNK_WIDTH(2), .TIE_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .hvin_valid(t_valid), .hvin(t_hvin),
        .hvin_ready(c_in_rdy), .hvout_valid(c_out_vld), .hvout_ready(t_out_rdy),
        .hvout(c_hvout), .state_dbg(c_state)
    );

    task automatic test_reset();
        rst_n = 1'b0; a_valid = '0; a_hvin = '0; a_out_rdy = 1'b0;
        t_valid = '0; t_hvin = '0; t_out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (a_hvout !== 8'h00 || a_out_vld !== 1'b0) begin bad++;
            $display("FAIL reset_out: hvout=%h valid=%b want 00/0", a_hvout, a_out_vld); end
        total++; if (a_in_rdy !== 1'b0) begin bad++;
            $display("FAIL reset_in_rdy: got %b want 0", a_in_rdy); end
        total++; if (a_state !== S_IDLE || b_state !== S_IDLE) begin bad++;
            $display("FAIL reset_state: a=%0d b=%0d want 0", a_state, b_state); end
        rst_n = 1'b1;
        #1;
        total++; if (a_in_rdy !== 1'b1) begin bad++;
            $display("FAIL idle_in_rdy: got %b want 1", a_in_rdy); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        a_hvin = {8'hAA, 8'hCC, 8'hF0}; a_valid = 3'b111; a_out_rdy = 1'b1;
        @(negedge clk);                       // after E0
        a_valid = '0; a_hvin = 24'h5A3C96;    // changes after accept must not matter
        total++; if (a_state !== S_COMPUTE) begin bad++;
            $display("FAIL basic_state: got %0d want 1", a_state); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);                   // after E0+k
            total++; if (a_out_vld !== (k == 4)) begin bad++;
                $display("FAIL basic_valid k=%0d: got %b want %b", k, a_out_vld, (k == 4)); end
        end
        total++; if (a_hvout !== 8'hE8) begin bad++;
            $display("FAIL basic_result: got %h want e8", a_hvout); end
        @(negedge clk);
        total++; if (a_state !== S_IDLE || a_out_vld !== 1'b0) begin bad++;
            $display("FAIL basic_release: state=%0d valid=%b want 0/0", a_state, a_out_vld); end
    endtask

    task automatic test_partial();
        a_hvin = {8'h55, 8'h33, 8'h0F}; a_valid = 3'b011; a_out_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (a_state !== S_IDLE || a_out_vld !== 1'b0) begin bad++;
                $display("FAIL partial_idle c=%0d: state=%0d valid=%b want 0/0", k, a_state, a_out_vld); end
        end
        a_valid = 3'b111; a_out_rdy = 1'b0;
        @(negedge clk);
        a_valid = '0;
        total++; if (a_state !== S_COMPUTE) begin bad++;
            $display("FAIL partial_accept: state=%0d want 1", a_state); end
    endtask

    // Continues from the accept made in test_partial (majority of 0F/33/55 = 17).
    task automatic test_backpressure();
        repeat (4) @(negedge clk);
        total++; if (a_out_vld !== 1'b1 || a_hvout !== 8'h17) begin bad++;
            $display("FAIL bp_result: valid=%b hvout=%h want 1/17", a_out_vld, a_hvout); end
        a_hvin = {8'hFF, 8'hFF, 8'hFF}; a_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (a_hvout !== 8'h17 || a_out_vld !== 1'b1 || a_in_rdy !== 1'b0 || a_state !== S_DONE) begin bad++;
                $display("FAIL bp_hold c=%0d: hvout=%h valid=%b in_rdy=%b state=%0d want 17/1/0/2",
                         k, a_hvout, a_out_vld, a_in_rdy, a_state); end
        end
        a_out_rdy = 1'b1;
        #1;
        total++; if (a_in_rdy !== 1'b1) begin bad++;
            $display("FAIL bp_in_rdy: got %b want 1", a_in_rdy); end
        @(negedge clk);                       // after handoff edge E1
        a_valid = '0;
        total++; if (a_state !== S_COMPUTE || a_out_vld !== 1'b0) begin bad++;
            $display("FAIL bp_handoff: state=%0d valid=%b want 1/0", a_state, a_out_vld); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++; if (a_out_vld !== (k == 4)) begin bad++;
                $display("FAIL bp_valid k=%0d: got %b want %b", k, a_out_vld, (k == 4)); end
        end
        total++; if (a_hvout !== 8'hFF) begin bad++;
            $display("FAIL bp_second: got %h want ff", a_hvout); end
        @(negedge clk);
        total++; if (a_state !== S_IDLE) begin bad++;
            $display("FAIL bp_idle: got %0d want 0", a_state); end
    endtask

    task automatic test_tie(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                            input logic [7:0] m3, input logic [7:0] exp_rot, input logic [7:0] exp_zero);
        @(negedge clk);
        t_hvin = {m3, m2, m1, m0}; t_valid = 4'hF; t_out_rdy = 1'b1;
        @(negedge clk);
        t_valid = '0;
        repeat (4) @(negedge clk);
        total++; if (b_out_vld !== 1'b1 || b_hvout !== exp_rot) begin bad++;
            $display("FAIL tie_rotate: valid=%b hvout=%h want 1/%h", b_out_vld, b_hvout, exp_rot); end
        total++; if (c_out_vld !== 1'b1 || c_hvout !== exp_zero) begin bad++;
            $display("FAIL tie_zero: valid=%b hvout=%h want 1/%h", c_out_vld, c_hvout, exp_zero); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_hvin = {8'hAA, 8'hCC, 8'hF0}; a_valid = 3'b111; a_out_rdy = 1'b1;
        @(posedge clk);                       // E0
        #1 a_valid = '0;
        repeat (2) @(posedge clk);            // E0+2: two chunks already written
        #1 rst_n = 1'b0;
        #1;
        total++; if (a_hvout !== 8'h00 || a_out_vld !== 1'b0) begin bad++;
            $display("FAIL midrst_out: hvout=%h valid=%b want 00/0", a_hvout, a_out_vld); end
        total++; if (a_state !== S_IDLE || a_in_rdy !== 1'b0) begin bad++;
            $display("FAIL midrst_state: state=%0d in_rdy=%b want 0/0", a_state, a_in_rdy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if (a_out_vld !== 1'b0 || a_state !== S_IDLE) begin bad++;
                $display("FAIL midrst_spurious c=%0d: valid=%b state=%0d want 0/0", k, a_out_vld, a_state); end
        end
        a_hvin = {8'h55, 8'h33, 8'h0F}; a_valid = 3'b111;
        @(negedge clk);
        a_valid = '0;
        repeat (4) @(negedge clk);
        total++; if (a_out_vld !== 1'b1 || a_hvout !== 8'h17) begin bad++;
            $display("FAIL midrst_recover: valid=%b hvout=%h want 1/17", a_out_vld, a_hvout); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [7:0] m0, m1, m2, got, exp;
        a_out_rdy = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 20; v++) begin
            m0 = 8'($urandom_range(0, 255));
            m1 = 8'($urandom_range(0, 255));
            m2 = 8'($urandom_range(0, 255));
            a_hvin = {m2, m1, m0}; a_valid = 3'b111;
            exp_q.push_back((m0 & m1) | (m0 & m2) | (m1 & m2));
            #1;
            total++; if (a_in_rdy !== 1'b1) begin bad++;
                $display("FAIL stream_in_rdy v=%0d: got %b want 1", v, a_in_rdy); end
            @(negedge clk);
            a_valid = '0; a_hvin = 24'($urandom);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                total++; if (a_out_vld !== (k == 4)) begin bad++;
                    $display("FAIL stream_valid v=%0d k=%0d: got %b want %b", v, k, a_out_vld, (k == 4)); end
            end
            got = a_hvout;
            exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++;
                $display("FAIL stream_data v=%0d: got %h want %h", v, got, exp); end
        end
        @(negedge clk);
        total++; if (a_state !== S_IDLE) begin bad++;
            $display("FAIL stream_end: state=%0d want 0", a_state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_tie(8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h87, 8'h00);
        test_tie(8'h3C, 8'h0F, 8'hF0, 8'hFF, 8'h3E, 8'h3C);
        test_reset_mid();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

endmodule
